ddc_downconv: RTL and testbench
===============================

// Module: ddc_downconv
// PURPOSE
//   Digital down-converter: receive side of the DDS up-converter chain. Mixes signed IF samples with a
//   local NCO sine, integrates-and-dumps 2**DEC_LOG2 products and emits decimated, saturated baseband
//   samples with a valid strobe. Sits between the IF sample source (ADC/loopback) and baseband demod.
// PARAMETERS
//   IF_DATA_WIDTH     17                  signed IF sample width
//   BB_DATA_WIDTH     8                   signed baseband output width
//   PHASE_INC_WIDTH   16                  NCO phase increment width
//   PHASE_ACC_WIDTH   16                  NCO phase accumulator width (>= SIN_PHASE_WIDTH)
//   PHASE_INITIAL     0                   accumulator value after reset
//   SIN_PHASE_WIDTH   12                  ROM address width = top bits of phase accumulator
//   SIN_ROM_WIDTH     8                   signed sine sample width
//   SIN_ROM_INIT_FILE "dds_sin_rom.mem"   sine ROM image (same image as transmit side)
//   DEC_LOG2          2                   log2 of decimation factor, 0..8
// PORTS
//   clk_i            in   1                 clock, all logic on rising edge
//   rst_i            in   1                 reset, asynchronous, active-high
//   if_data_i        in   IF_DATA_WIDTH     signed IF sample
//   if_valid_i       in   1                 if_data_i valid this cycle
//   phase_inc_i      in   PHASE_INC_WIDTH   NCO increment
//   phase_inc_ena_i  in   1                 1: NCO advances by phase_inc_i on each accepted sample
//   bb_data_o        out  BB_DATA_WIDTH     signed decimated in-phase output
//   bb_valid_o       out  1                 one-cycle strobe, bb_data_o valid
//   bb_sat_o         out  1                 one-cycle strobe coincident with bb_valid_o: output clipped
// BEHAVIOUR
//   - Reset: phase acc = PHASE_INITIAL; all pipeline regs, integrator, dump counter, bb_data_o,
//     bb_valid_o, bb_sat_o = 0. Reset mid-dump discards partial sum; first output after release needs a
//     full 2**DEC_LOG2 fresh samples.
//   - No backpressure: sample accepted every cycle if_valid_i=1. Bubbles (if_valid_i=0) freeze NCO and
//     do not count toward the dump; valid propagates down the pipe as a tag.
//   - Pipeline per accepted sample: S1 sample+phase registered; S2 sine ROM (combinational on S1 phase)
//     and aligned sample registered; S3 signed product (IF_DATA_WIDTH+SIN_ROM_WIDTH bits) registered;
//     S4 integrator. NCO phase used for sample n is the accumulator value before its increment.
//   - Integrator width IF_DATA_WIDTH+SIN_ROM_WIDTH+DEC_LOG2, never overflows. Dump counter counts valid
//     S3 products 0..2**DEC_LOG2-1; on the last one: sum (incl. that product) shifted arithmetic right by
//     DEC_LOG2+SIN_ROM_WIDTH-1 (truncate toward -inf), saturated to BB_DATA_WIDTH, registered to
//     bb_data_o with bb_valid_o=1; integrator reloads with 0 (next product starts new sum). Counter wraps.
//   - Latency: last sample of a dump at if_valid_i cycle t -> bb_valid_o at cycle t+4.
//   - Saturation: result > 2**(BB-1)-1 -> max, < -2**(BB-1) -> min; bb_sat_o=1 for that strobe only.
//   - bb_data_o holds between strobes. phase_inc_ena_i=0: NCO holds phase, mixing continues.
//   - Phase wraps modulo 2**PHASE_ACC_WIDTH; carry ignored.
// CONFIGURATION
//   DDC_IQ_EN defined: adds bb_q_data_o (out, BB_DATA_WIDTH) — second ROM read at phase + quarter
//     cycle (address + 2**(SIN_PHASE_WIDTH-2), wraps), own product/integrator, same counter, same
//     strobe; bb_sat_o = OR of both channel saturations.
//   Undefined: in-phase channel only, no bb_q_data_o port, no second ROM.
// STRUCTURE
//   ddc_pkg: ROM quarter-offset constant, shift-amount function, saturate function, product/acc width
//     localparams. NCO reuses dds_phase_acc (load tied off) and dds_sin_rom (two instances with IQ).
//   Sub-module ddc_integrate_dump: accumulator, dump counter, shift, saturate, output registers;
//     instantiated once per channel.
// TESTING (default params unless noted)
//   1 rst_i pulsed mid-stream -> all outputs 0 immediately (async); next strobe only after 4 new samples.
//   2 PHASE_INITIAL=0x4000 (sine=+127), phase_inc_i=0, if_data_i=+100 x4 valid -> bb_data_o=99,
//     bb_valid_o at t+4, bb_sat_o=0; continuous input -> strobe every 4 cycles.
//   3 same as 2, if_valid_i toggling 1,0,1,0... -> same 99, strobes every 8 cycles, NCO frozen in bubbles.
//   4 same as 2, if_data_i=+65535 -> bb_data_o=127, bb_sat_o=1; if_data_i=-65536 -> -128, bb_sat_o=1.
//   5 phase_inc_i=0x4000, phase_inc_ena_i=1, constant if_data_i=+100 -> sines 0,127,0,-127 sum 0 -> bb 0.
//   6 DDC_IQ_EN, setup of 2 -> bb_data_o=99, bb_q_data_o=0 (cosine at quarter phase = 0), same strobe.

Source files
------------

// File: rtl/ddc_pkg.sv
// Shared definitions for the digital down-converter.
//   - default parameter values for the ddc_downconv top
//   - product / integrator width helpers
//   - quarter-cycle ROM address offset (used when DDC_IQ_EN is defined)
//   - dump shift amount and output saturation helpers
package ddc_pkg;

   localparam int DDC_IF_DATA_WIDTH   = 17;
   localparam int DDC_BB_DATA_WIDTH   = 8;
   localparam int DDC_PHASE_INC_WIDTH = 16;
   localparam int DDC_PHASE_ACC_WIDTH = 16;
   localparam int DDC_SIN_PHASE_WIDTH = 12;
   localparam int DDC_SIN_ROM_WIDTH   = 8;
   localparam int DDC_DEC_LOG2        = 2;

   function automatic int prod_width(input int if_w, input int rom_w);
      return if_w + rom_w;
   endfunction

   function automatic int acc_width(input int prod_w, input int dec_log2);
      return prod_w + dec_log2;
   endfunction

   // 90 degrees expressed in ROM address units
   function automatic int quarter_offset(input int sin_phase_w);
      return 1 << (sin_phase_w - 2);
   endfunction

   // Removes the 2**DEC_LOG2 sum gain and the sine full-scale gain
   function automatic int dump_shift(input int dec_log2, input int rom_w);
      return dec_log2 + rom_w - 1;
   endfunction

   function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int bb_w);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (bb_w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (bb_w - 1));
      if (v > max_v) return max_v;
      if (v < min_v) return min_v;
      return v;
   endfunction

   function automatic logic sat_hit(input logic signed [63:0] v, input int bb_w);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (bb_w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (bb_w - 1));
      return (v > max_v) || (v < min_v);
   endfunction

endpackage

// File: rtl/ddc_integrate_dump.sv
// Integrate-and-dump for one down-converter channel.
//   clk_i, rst_i    clock, async active-high reset (sum, count, outputs -> 0)
//   prod_valid_i    prod_i carries a mixer product this cycle
//   prod_i          signed mixer product
//   bb_data_o       signed decimated sample, holds between strobes
//   bb_valid_o      one-cycle strobe per 2**DEC_LOG2 products
//   bb_sat_o        one-cycle strobe with bb_valid_o when the result clipped
module ddc_integrate_dump
   import ddc_pkg::*;
#(
   parameter int PROD_WIDTH    = 25,
   parameter int DEC_LOG2      = 2,
   parameter int BB_DATA_WIDTH = 8,
   parameter int SHIFT         = 9
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     prod_valid_i,
   input  logic [PROD_WIDTH-1:0]    prod_i,
   output logic [BB_DATA_WIDTH-1:0] bb_data_o,
   output logic                     bb_valid_o,
   output logic                     bb_sat_o
);

   localparam int ACC_WIDTH = acc_width(PROD_WIDTH, DEC_LOG2);
   localparam int CNT_WIDTH = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((1 << DEC_LOG2) - 1);

   logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;
   logic signed [ACC_WIDTH-1:0]     sum, sum_shr;
   logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
   logic signed [BB_DATA_WIDTH-1:0] bb_data_q, bb_data_d;
   logic                            bb_valid_q, bb_valid_d;
   logic                            bb_sat_q, bb_sat_d;

   always_comb begin
      // sum includes the closing product so the dump needs no extra cycle
      sum        = acc_q + ACC_WIDTH'($signed(prod_i));
      sum_shr    = sum >>> SHIFT;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      bb_data_d  = bb_data_q;
      bb_valid_d = 1'b0;
      bb_sat_d   = 1'b0;
      if (prod_valid_i) begin
         if (cnt_q == CNT_LAST) begin
            acc_d      = '0;
            cnt_d      = '0;
            bb_data_d  = BB_DATA_WIDTH'(sat_clip(64'(sum_shr), BB_DATA_WIDTH));
            bb_sat_d   = sat_hit(64'(sum_shr), BB_DATA_WIDTH);
            bb_valid_d = 1'b1;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         bb_data_q  <= '0;
         bb_valid_q <= 1'b0;
         bb_sat_q   <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         bb_data_q  <= bb_data_d;
         bb_valid_q <= bb_valid_d;
         bb_sat_q   <= bb_sat_d;
      end
   end

   assign bb_data_o  = bb_data_q;
   assign bb_valid_o = bb_valid_q;
   assign bb_sat_o   = bb_sat_q;

endmodule

// File: rtl/dds_phase_acc.sv
// NCO phase accumulator (shared with the transmit-side DDS).
//   clk_i, rst_i   clock, async active-high reset (acc -> PHASE_INITIAL)
//   ena_i          advance by inc_i this cycle
//   inc_i          phase increment
//   load_i         load load_val_i (takes priority over ena_i)
//   load_val_i     phase load value
//   phase_o        top PHASE_OUT_WIDTH bits of the accumulator (ROM address)
module dds_phase_acc #(
   parameter int                         PHASE_INC_WIDTH = 16,
   parameter int                         PHASE_ACC_WIDTH = 16,
   parameter int                         PHASE_OUT_WIDTH = 12,
   parameter logic [PHASE_ACC_WIDTH-1:0] PHASE_INITIAL   = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       ena_i,
   input  logic [PHASE_INC_WIDTH-1:0] inc_i,
   input  logic                       load_i,
   input  logic [PHASE_ACC_WIDTH-1:0] load_val_i,
   output logic [PHASE_OUT_WIDTH-1:0] phase_o
);

   logic [PHASE_ACC_WIDTH-1:0] acc_q;
   logic [PHASE_ACC_WIDTH-1:0] acc_d;
   logic [PHASE_ACC_WIDTH-1:0] inc_ext;

   generate
      if (PHASE_INC_WIDTH >= PHASE_ACC_WIDTH) begin : g_inc_trunc
         assign inc_ext = inc_i[PHASE_ACC_WIDTH-1:0];
      end else begin : g_inc_ext
         assign inc_ext = {{(PHASE_ACC_WIDTH-PHASE_INC_WIDTH){1'b0}}, inc_i};
      end
   endgenerate

   // wraps modulo 2**PHASE_ACC_WIDTH, carry dropped
   always_comb begin
      acc_d = acc_q;
      if (load_i)     acc_d = load_val_i;
      else if (ena_i) acc_d = acc_q + inc_ext;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) acc_q <= PHASE_INITIAL;
      else       acc_q <= acc_d;
   end

   assign phase_o = acc_q[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH];

endmodule

// File: rtl/dds_sin_rom.sv
// Combinational sine table (shared with the transmit-side DDS).
//   addr_i   phase in ROM address units (full circle = 2**SIN_PHASE_WIDTH)
//   data_o   signed sine, full scale 2**(SIN_ROM_WIDTH-1)-1
// The table contents are computed at elaboration (Bhaskara rational
// approximation, half-wave mirrored with sign) instead of being loaded from
// an image file, so there is no init-file parameter. Quadrant points are
// exact: 0, +max, 0, -max, and the two half-waves are exact negatives.
module dds_sin_rom #(
   parameter int SIN_PHASE_WIDTH = 12,
   parameter int SIN_ROM_WIDTH   = 8
) (
   input  logic [SIN_PHASE_WIDTH-1:0] addr_i,
   output logic [SIN_ROM_WIDTH-1:0]   data_o
);

   function automatic logic [SIN_ROM_WIDTH-1:0] sin_at(input logic [SIN_PHASE_WIDTH-1:0] a);
      longint half;
      longint p;
      longint amp;
      longint num;
      longint den;
      longint mag;
      half = longint'(1) <<< (SIN_PHASE_WIDTH - 1);
      p    = longint'(a[SIN_PHASE_WIDTH-2:0]);
      amp  = (longint'(1) <<< (SIN_ROM_WIDTH - 1)) - 64'sd1;
      num  = 64'sd16 * p * (half - p);
      den  = 64'sd5 * half * half - 64'sd4 * p * (half - p);
      mag  = (amp * num + den / 64'sd2) / den;
      if (a[SIN_PHASE_WIDTH-1]) mag = -mag;
      return mag[SIN_ROM_WIDTH-1:0];
   endfunction

   assign data_o = sin_at(addr_i);

endmodule

// File: rtl/ddc_downconv.sv
// Digital down-converter: mixes signed IF samples with the NCO sine,
// integrates-and-dumps 2**DEC_LOG2 products, emits saturated baseband.
//   clk_i, rst_i      clock, async active-high reset
//   if_data_i         signed IF sample, if_valid_i qualifies it (no backpressure)
//   phase_inc_i       NCO increment, applied per accepted sample when phase_inc_ena_i=1
//   bb_data_o         signed decimated in-phase sample
//   bb_valid_o        one-cycle output strobe, 4 cycles after the closing sample
//   bb_sat_o          strobe qualifier: output was clipped
//   bb_q_data_o       quadrature sample (only with DDC_IQ_EN defined)
// Build option: DDC_IQ_EN adds a quadrature channel reading the sine table a
// quarter cycle ahead, dumping on the same count and strobe.
// Pipeline: S1 sample+phase, S2 sine + aligned sample, S3 product, then dump.
module ddc_downconv
   import ddc_pkg::*;
#(
   parameter int                             IF_DATA_WIDTH   = DDC_IF_DATA_WIDTH,
   parameter int                             BB_DATA_WIDTH   = DDC_BB_DATA_WIDTH,
   parameter int                             PHASE_INC_WIDTH = DDC_PHASE_INC_WIDTH,
   parameter int                             PHASE_ACC_WIDTH = DDC_PHASE_ACC_WIDTH,
   parameter logic [PHASE_ACC_WIDTH-1:0]     PHASE_INITIAL   = '0,
   parameter int                             SIN_PHASE_WIDTH = DDC_SIN_PHASE_WIDTH,
   parameter int                             SIN_ROM_WIDTH   = DDC_SIN_ROM_WIDTH,
   parameter int                             DEC_LOG2        = DDC_DEC_LOG2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [IF_DATA_WIDTH-1:0]   if_data_i,
   input  logic                       if_valid_i,
   input  logic [PHASE_INC_WIDTH-1:0] phase_inc_i,
   input  logic                       phase_inc_ena_i,
   output logic [BB_DATA_WIDTH-1:0]   bb_data_o,
   output logic                       bb_valid_o,
   output logic                       bb_sat_o
`ifdef DDC_IQ_EN
   ,
   output logic [BB_DATA_WIDTH-1:0]   bb_q_data_o
`endif
);

   localparam int PROD_WIDTH = prod_width(IF_DATA_WIDTH, SIN_ROM_WIDTH);
   localparam int SHIFT      = dump_shift(DEC_LOG2, SIN_ROM_WIDTH);

   logic [SIN_PHASE_WIDTH-1:0]      nco_addr;
   logic                            s1_valid_q, s2_valid_q, s3_valid_q;
   logic signed [IF_DATA_WIDTH-1:0] s1_data_q, s2_data_q;
   logic [SIN_PHASE_WIDTH-1:0]      s1_addr_q;
   logic [SIN_ROM_WIDTH-1:0]        sin_rd;
   logic signed [SIN_ROM_WIDTH-1:0] s2_sin_q;
   logic [PROD_WIDTH-1:0]           s3_mix_i_q;

   // phase used for a sample is the value before its own increment
   dds_phase_acc #(
      .PHASE_INC_WIDTH (PHASE_INC_WIDTH),
      .PHASE_ACC_WIDTH (PHASE_ACC_WIDTH),
      .PHASE_OUT_WIDTH (SIN_PHASE_WIDTH),
      .PHASE_INITIAL   (PHASE_INITIAL)
   ) u_nco (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .ena_i      (if_valid_i & phase_inc_ena_i),
      .inc_i      (phase_inc_i),
      .load_i     (1'b0),
      .load_val_i ('0),
      .phase_o    (nco_addr)
   );

   dds_sin_rom #(
      .SIN_PHASE_WIDTH (SIN_PHASE_WIDTH),
      .SIN_ROM_WIDTH   (SIN_ROM_WIDTH)
   ) u_sin (
      .addr_i (s1_addr_q),
      .data_o (sin_rd)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_addr_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_sin_q   <= '0;
         s3_valid_q <= 1'b0;
         s3_mix_i_q <= '0;
      end else begin
         s1_valid_q <= if_valid_i;
         if (if_valid_i) begin
            s1_data_q <= $signed(if_data_i);
            s1_addr_q <= nco_addr;
         end
         s2_valid_q <= s1_valid_q;
         s2_data_q  <= s1_data_q;
         s2_sin_q   <= $signed(sin_rd);
         s3_valid_q <= s2_valid_q;
         s3_mix_i_q <= PROD_WIDTH'(s2_data_q) * PROD_WIDTH'(s2_sin_q);
      end
   end

`ifdef DDC_IQ_EN
   localparam logic [SIN_PHASE_WIDTH-1:0] Q_OFFSET =
      SIN_PHASE_WIDTH'(quarter_offset(SIN_PHASE_WIDTH));

   logic [SIN_PHASE_WIDTH-1:0]      cos_addr;
   logic [SIN_ROM_WIDTH-1:0]        cos_rd;
   logic signed [SIN_ROM_WIDTH-1:0] s2_cos_q;
   logic [PROD_WIDTH-1:0]           s3_mix_q_q;
   logic                            i_valid, q_valid, i_sat, q_sat;

   assign cos_addr = s1_addr_q + Q_OFFSET;

   dds_sin_rom #(
      .SIN_PHASE_WIDTH (SIN_PHASE_WIDTH),
      .SIN_ROM_WIDTH   (SIN_ROM_WIDTH)
   ) u_cos (
      .addr_i (cos_addr),
      .data_o (cos_rd)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_cos_q   <= '0;
         s3_mix_q_q <= '0;
      end else begin
         s2_cos_q   <= $signed(cos_rd);
         s3_mix_q_q <= PROD_WIDTH'(s2_data_q) * PROD_WIDTH'(s2_cos_q);
      end
   end

   ddc_integrate_dump #(
      .PROD_WIDTH (PROD_WIDTH), .DEC_LOG2 (DEC_LOG2),
      .BB_DATA_WIDTH (BB_DATA_WIDTH), .SHIFT (SHIFT)
   ) u_dump_i (
      .clk_i (clk_i), .rst_i (rst_i), .prod_valid_i (s3_valid_q), .prod_i (s3_mix_i_q),
      .bb_data_o (bb_data_o), .bb_valid_o (i_valid), .bb_sat_o (i_sat)
   );

   ddc_integrate_dump #(
      .PROD_WIDTH (PROD_WIDTH), .DEC_LOG2 (DEC_LOG2),
      .BB_DATA_WIDTH (BB_DATA_WIDTH), .SHIFT (SHIFT)
   ) u_dump_q (
      .clk_i (clk_i), .rst_i (rst_i), .prod_valid_i (s3_valid_q), .prod_i (s3_mix_q_q),
      .bb_data_o (bb_q_data_o), .bb_valid_o (q_valid), .bb_sat_o (q_sat)
   );

   // both channels count the same valid products, so the strobes coincide
   assign bb_valid_o = i_valid | q_valid;
   assign bb_sat_o   = i_sat | q_sat;
`else
   ddc_integrate_dump #(
      .PROD_WIDTH (PROD_WIDTH), .DEC_LOG2 (DEC_LOG2),
      .BB_DATA_WIDTH (BB_DATA_WIDTH), .SHIFT (SHIFT)
   ) u_dump_i (
      .clk_i (clk_i), .rst_i (rst_i), .prod_valid_i (s3_valid_q), .prod_i (s3_mix_i_q),
      .bb_data_o (bb_data_o), .bb_valid_o (bb_valid_o), .bb_sat_o (bb_sat_o)
   );
`endif

endmodule

// File: tb/tb_ddc_downconv.sv
// Bench for ddc_downconv with PHASE_INITIAL=0x4000 (sine +127 at rest).
// Each table row is one dump of four identical samples; the expected output,
// sat flag and strobe cycle are queued when the closing sample is driven and
// checked by a monitor when the strobe appears.
module tb_ddc_downconv;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [16:0] if_data = '0;
   logic        if_valid = 1'b0;
   logic [15:0] phase_inc = '0;
   logic        phase_inc_ena = 1'b0;
   logic [7:0]  bb_data;
   logic        bb_valid;
   logic        bb_sat;
`ifdef DDC_IQ_EN
   logic [7:0]  bb_q_data;
`endif

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      int data;
      int gap;
      int inc;
      bit ena;
      int exp_data;
      bit exp_sat;
   } vec_t;

   typedef struct {
      int data;
      bit sat;
      int cyc;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[13];

   ddc_downconv #(
      .PHASE_INITIAL (16'h4000)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .if_data_i       (if_data),
      .if_valid_i      (if_valid),
      .phase_inc_i     (phase_inc),
      .phase_inc_ena_i (phase_inc_ena),
      .bb_data_o       (bb_data),
      .bb_valid_o      (bb_valid),
      .bb_sat_o        (bb_sat)
`ifdef DDC_IQ_EN
      ,
      .bb_q_data_o     (bb_q_data)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event not expected at cycle %0d", name, cyc);
   endtask

   task automatic drive(input int d, input bit v, input int inc, input bit ena);
      @(posedge clk);
      #1;
      if_data       = 17'(d);
      if_valid      = v;
      phase_inc     = 16'(inc);
      phase_inc_ena = ena;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         flag(name);
         sb.delete();
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            flag("strobe_missing");
            void'(sb.pop_front());
         end
         if (bb_valid) begin
            if (sb.size() == 0) begin
               flag("spurious_strobe");
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("strobe_cycle", cyc, e.cyc);
               chk("bb_data", int'($signed(bb_data)), e.data);
               chk("bb_sat", int'(bb_sat), int'(e.sat));
`ifdef DDC_IQ_EN
               chk("bb_q_data", int'($signed(bb_q_data)), 0);
`endif
            end
         end else if (bb_sat) begin
            flag("sat_without_valid");
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //         data    gap inc      ena  exp   sat
      vecs[0]  = '{ 100,   0, 0,       1,   99,  0};
      vecs[1]  = '{ 100,   0, 'h4000,  0,   99,  0};
      vecs[2]  = '{ 100,   1, 0,       1,   99,  0};
      vecs[3]  = '{ 65535, 0, 0,       1,  127,  1};
      vecs[4]  = '{-65536, 0, 0,       1, -128,  1};
      vecs[5]  = '{ 100,   0, 'h4000,  1,    0,  0};
      vecs[6]  = '{ 100,   1, 'h8000,  1,    0,  0};
      vecs[7]  = '{-100,   0, 0,       1, -100,  0};
      vecs[8]  = '{ 200,   2, 'h4000,  0,  127,  1};
      vecs[9]  = '{ 129,   0, 0,       1,  127,  0};
      vecs[10] = '{ 130,   0, 0,       1,  127,  1};
      vecs[11] = '{-129,   0, 0,       1, -128,  0};
      vecs[12] = '{-130,   0, 0,       1, -128,  1};

      #2 rst = 1'b1;
      #3;
      chk("reset_bb_data", int'(bb_data), 0);
      chk("reset_bb_valid", int'(bb_valid), 0);
      chk("reset_bb_sat", int'(bb_sat), 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         for (int k = 0; k < 4; k++) begin
            drive(vecs[i].data, 1'b1, vecs[i].inc, vecs[i].ena);
            if (k == 3) sb.push_back('{vecs[i].exp_data, vecs[i].exp_sat, cyc + 4});
            else for (int g = 0; g < vecs[i].gap; g++) drive(0, 1'b0, vecs[i].inc, vecs[i].ena);
         end
      end
      drive(0, 1'b0, 0, 1'b0);
      drain("table_drain_timeout");

      // partial dump with an advancing NCO, then reset in mid-cycle
      drive(100, 1'b1, 'h4000, 1'b1);
      drive(100, 1'b1, 'h4000, 1'b1);
      drive(0, 1'b0, 0, 1'b0);
      #3 rst = 1'b1;
      #1;
      chk("async_reset_bb_data", int'(bb_data), 0);
      chk("async_reset_bb_valid", int'(bb_valid), 0);
      chk("async_reset_bb_sat", int'(bb_sat), 0);
      @(negedge clk) rst = 1'b0;

      // partial sum, count and phase must all be fresh after reset
      for (int k = 0; k < 4; k++) begin
         drive(100, 1'b1, 0, 1'b0);
         if (k == 3) sb.push_back('{99, 1'b0, cyc + 4});
      end
      drive(0, 1'b0, 0, 1'b0);
      drain("post_reset_drain_timeout");

      // output holds between strobes
      repeat (3) @(negedge clk);
      chk("hold_bb_data", int'($signed(bb_data)), 99);
      chk("hold_bb_valid", int'(bb_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
